jt1942_sdram_prog: RTL and testbench

- Sits directly downstream of the ROM-download address/mask writer.
- Captures each byte-programming strike (prog_addr/prog_data/prog_mask/prog_we) into a small FIFO and replays it to the SDRAM controller with a req/ack handshake.
- Drops PROM-only strikes, which carry mask 2'b11 and hold no SDRAM lanes.
- Reports when the whole download has been committed to SDRAM.

---
 rtl/jt1942_sdram_prog.sv | 127 ++++++++++++
 tb/tb_jt1942_sdram_prog.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1942_sdram_prog.sv
// Buffers ROM-download byte strikes in a small FIFO and replays them to the SDRAM
// controller over a req/ack handshake; flags completion once the download is fully committed.
//   state | meaning
//   IDLE  | waiting for a queued strike
//   REQ   | write request held until the controller acks
//   GAP   | one dead cycle between writes
module jt1942_sdram_prog #(
    parameter int AW         = 22,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic          clk_rom,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-1:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_dqm,
    output logic          prog_busy,
    output logic          prog_done,
    output logic          overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = AW + 10;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state, state_nxt;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  prog_we_l, dl_l, armed;
    logic                  strike, push, pop, full, not_empty, load;

    assign strike    = prog_we & ~prog_we_l & (prog_mask != 2'b11);
    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
    assign push      = strike & (~full | pop);

    always_ff @(posedge clk_rom) begin
        if (push) mem[wr_ptr] <= {prog_addr, prog_data, prog_mask};
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            prog_we_l <= 1'b0;
        end else begin
            prog_we_l <= prog_we;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)      count <= count + 1'b1;
            else if (~push & pop) count <= count - 1'b1;
            if (strike & full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (not_empty) state_nxt = REQ;
            REQ:     if (sdram_ack) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) & not_empty;
        pop  = (state == REQ) & sdram_ack;
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_dqm  <= 2'b11;
        end else begin
            sdram_req <= (state_nxt == REQ);
            if (load) begin
                sdram_addr <= head[EW-1:10];
                sdram_din  <= {head[9:2], head[9:2]};
                sdram_dqm  <= head[1:0];
            end
        end
    end

    // Completion is armed by the end of the download and waits for the queue to drain.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            prog_busy <= 1'b0;
            prog_done <= 1'b0;
            dl_l      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            prog_busy <= not_empty | (state != IDLE);
            dl_l      <= downloading;
            if (downloading & ~dl_l) begin
                armed     <= 1'b0;
                prog_done <= 1'b0;
            end else if (dl_l & ~downloading) begin
                armed <= 1'b1;
            end else if (armed & ~prog_done & ~not_empty & (state == IDLE)) begin
                prog_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jt1942_sdram_prog.sv
// Bench for jt1942_sdram_prog: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based model of the write stream.
module tb_jt1942_sdram_prog;

    logic        clk_rom = 1'b0;
    logic        rst, downloading, prog_we, sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        sdram_req, prog_busy, prog_done, overflow;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_dqm;

    int total = 0;
    int bad   = 0;

    always #5 clk_rom = ~clk_rom;

    jt1942_sdram_prog #(.AW(22), .DEPTH_LOG2(2)) dut (
        .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_dqm(sdram_dqm),
        .prog_busy(prog_busy), .prog_done(prog_done), .overflow(overflow)
    );

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        int          we_len;
        int          ack_dly;
        bit          exp_req;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        prog_we   = 1'b0;
        sdram_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic strike(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
        tick();
    endtask

    task automatic wait_req(input string name);
        for (int c = 0; c < 20 && !sdram_req; c++) tick();
        chk(name, sdram_req, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] e;
        logic        m_we_l, m_ovf, req_obs, pop, chkd, seen;
        int          n, reqs;

        vecs[0] = '{22'h000123, 8'hA5, 2'b01, 1, 2, 1'b1};
        vecs[1] = '{22'h0A5A5A, 8'h3C, 2'b10, 5, 0, 1'b1};
        vecs[2] = '{22'h3C0100, 8'h77, 2'b11, 1, 0, 1'b0};
        vecs[3] = '{22'h3FFFFF, 8'hFF, 2'b00, 3, 4, 1'b1};
        vecs[4] = '{22'h000000, 8'h00, 2'b11, 5, 0, 1'b0};

        downloading = 1'b1;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = '0;
        do_reset();
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_din", sdram_din, 0);
        chk("rst_dqm", sdram_dqm, 2'b11);
        chk("rst_busy", prog_busy, 0);
        chk("rst_done", prog_done, 0);
        chk("rst_ovf", overflow, 0);

        foreach (vecs[i]) begin
            prog_addr = vecs[i].addr;
            prog_data = vecs[i].data;
            prog_mask = vecs[i].mask;
            prog_we   = 1'b1;
            reqs      = 0;
            for (int c = 0; c < 30; c++) begin
                if (c == vecs[i].we_len) prog_we = 1'b0;
                tick();
                if (!vecs[i].exp_req) chk("prom_busy", prog_busy, 0);
                if (sdram_req) begin
                    reqs++;
                    chk("vec_addr", sdram_addr, vecs[i].addr);
                    chk("vec_din", sdram_din, {vecs[i].data, vecs[i].data});
                    chk("vec_dqm", sdram_dqm, vecs[i].mask);
                    repeat (vecs[i].ack_dly) begin
                        tick();
                        chk("vec_req_hold", sdram_req, 1);
                    end
                    sdram_ack = 1'b1;
                    tick();
                    sdram_ack = 1'b0;
                    chk("vec_req_drop", sdram_req, 0);
                end
            end
            prog_we = 1'b0;
            chk("vec_req_count", reqs, vecs[i].exp_req ? 1 : 0);
            chk("vec_busy_end", prog_busy, 0);
        end

        // Burst into a full FIFO with the controller stalled.
        do_reset();
        for (int i = 0; i < 6; i++)
            strike(22'h000100 + 22'(i), 8'h10 + 8'(i), (i % 2 == 1) ? 2'b01 : 2'b10);
        repeat (20) tick();
        chk("burst_ovf", overflow, 1);
        chk("burst_req_held", sdram_req, 1);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if (sdram_req) begin
                chk("burst_addr", sdram_addr, 22'h000100 + 22'(n));
                chk("burst_din", sdram_din, {2{8'h10 + 8'(n)}});
                chk("burst_dqm", sdram_dqm, (n % 2 == 1) ? 2'b01 : 2'b10);
                n++;
                sdram_ack = 1'b1;
                tick();
                sdram_ack = 1'b0;
            end else begin
                tick();
            end
        end
        chk("burst_writes", n, 4);
        chk("burst_ovf_sticky", overflow, 1);

        // Download ends while three writes are still queued.
        do_reset();
        for (int i = 0; i < 3; i++) strike(22'h002000 + 22'(i), 8'h5A, 2'b00);
        downloading = 1'b0;
        tick();
        chk("done_armed_busy", prog_done, 0);
        for (int k = 0; k < 3; k++) begin
            wait_req("done_req_wait");
            chk("done_early", prog_done, 0);
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            chk("done_after_ack", prog_done, 0);
        end
        tick();
        chk("done_plus1", prog_done, 0);
        tick();
        chk("done_plus2", prog_done, 1);
        repeat (3) tick();
        chk("done_hold", prog_done, 1);
        downloading = 1'b1;
        tick();
        chk("done_clear", prog_done, 0);

        // Reset while a request is outstanding.
        do_reset();
        strike(22'h003000, 8'h11, 2'b01);
        strike(22'h003001, 8'h22, 2'b10);
        wait_req("rst_req_wait");
        rst = 1'b1;
        tick();
        chk("midrst_req", sdram_req, 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (sdram_req) seen = 1'b1;
        end
        chk("midrst_no_req", seen, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_busy", prog_busy, 0);

        // Random traffic against a queue model of the ordered write stream.
        do_reset();
        m_we_l = 1'b0;
        m_ovf  = 1'b0;
        chkd   = 1'b0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c < 2800) begin
                prog_we   = ($urandom_range(0, 2) != 0);
                prog_addr = 22'($urandom);
                prog_data = 8'($urandom);
                prog_mask = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end else begin
                prog_we = 1'b0;
            end
            if (sdram_req) sdram_ack = (c >= 2800) || ($urandom_range(0, 2) == 0);
            else           sdram_ack = ($urandom_range(0, 7) == 0);
            req_obs = sdram_req;
            pop     = sdram_ack & req_obs;
            if (pop && q.size() > 0) begin
                void'(q.pop_front());
                chkd = 1'b0;
            end
            if (prog_we && !m_we_l && prog_mask != 2'b11) begin
                if (q.size() < 4) q.push_back({prog_addr, prog_data, prog_mask});
                else              m_ovf = 1'b1;
            end
            m_we_l = prog_we;
            tick();
            sdram_ack = 1'b0;
            if (c % 16 == 0) chk("rnd_ovf", overflow, m_ovf);
            if (q.size() == 0) begin
                if (sdram_req) chk("rnd_req_empty", sdram_req, 0);
            end else if (sdram_req && !chkd) begin
                e    = q[0];
                chkd = 1'b1;
                chk("rnd_addr", sdram_addr, e[31:10]);
                chk("rnd_din", sdram_din, {e[9:2], e[9:2]});
                chk("rnd_dqm", sdram_dqm, e[1:0]);
            end
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_ovf_end", overflow, m_ovf);
        chk("rnd_busy_end", prog_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
